// File: rtl/if_stage_param.sv
// Pipelined instruction-fetch stage: PC, loadable instruction memory and an IF/ID
// output register with valid/ready handshake, redirect/flush and optional jump predecode.
module if_stage_param #(
    parameter int                 INSTR_W   = 8,
    parameter int                 OPC_W     = 2,
    parameter int                 REG_W     = 3,
    parameter int                 ADDR_W    = 8,
    parameter int                 DEPTH     = 64,
    parameter logic [OPC_W-1:0]   JMP_OPC   = 2'b11,
    parameter int                 PREDECODE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [OPC_W-1:0]   opcode,
    output logic [REG_W-1:0]   rdest,
    output logic [REG_W-1:0]   rsrc,
    output logic [REG_W-1:0]   imm,
    output logic [ADDR_W-1:0]  jump_addr
);

    localparam int FLD_W = INSTR_W - OPC_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Bits of the PC replaced by the instruction's target field on a jump.
    localparam logic [ADDR_W-1:0] LOW_MASK =
        (ADDR_W > FLD_W) ? ADDR_W'((1 << FLD_W) - 1) : {ADDR_W{1'b1}};

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_next;
    logic [INSTR_W-1:0] rd_data;
    logic               advance;
    logic               is_jmp;

    function automatic logic [ADDR_W-1:0] jtgt(input logic [ADDR_W-1:0]  p,
                                               input logic [INSTR_W-1:0] i);
        return (p & ~LOW_MASK) | (ADDR_W'(i[FLD_W-1:0]) & LOW_MASK);
    endfunction

    // Addresses beyond the populated memory fetch as NOP.
    always_comb begin
        rd_data = '0;
        if (32'(pc) < DEPTH)
            rd_data = mem[pc[IDX_W-1:0]];
    end

    assign advance = !out_valid || out_ready;
    assign is_jmp  = (PREDECODE != 0) && (rd_data[INSTR_W-1 -: OPC_W] == JMP_OPC);
    assign pc_next = is_jmp ? jtgt(pc, rd_data) : pc + 1'b1;

    // Program port; contents survive reset.
    always_ff @(posedge clk) begin
        if (prog_we && (32'(prog_addr) < DEPTH))
            mem[prog_addr[IDX_W-1:0]] <= prog_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_instr <= '0;
        end else if (redirect_valid) begin
            pc        <= redirect_addr;
            out_valid <= 1'b0;
        end else if (advance) begin
            if (fetch_en) begin
                out_valid <= 1'b1;
                out_pc    <= pc;
                out_instr <= rd_data;
                pc        <= pc_next;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign opcode    = out_instr[INSTR_W-1 -: OPC_W];
    assign rdest     = out_instr[2*REG_W-1 -: REG_W];
    assign rsrc      = out_instr[REG_W-1:0];
    assign imm       = rsrc;
    assign jump_addr = jtgt(out_pc, out_instr);

endmodule

// File: tb/tb_if_stage_param.sv
// Directed, table-driven bench for if_stage_param; a PREDECODE=0 twin runs in lockstep.
module tb_if_stage_param;

    logic       clk = 1'b0;
    logic       reset, fetch_en, redirect_valid, prog_we, out_ready;
    logic [7:0] redirect_addr, prog_addr, prog_data;

    logic       v1, v2;
    logic [7:0] pc1, pc2, in1, in2, ja1, ja2;
    logic [1:0] op1, op2;
    logic [2:0] rd1, rd2, rs1, rs2, im1, im2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_stage_param #(.PREDECODE(1)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .out_ready(out_ready), .out_valid(v1), .out_pc(pc1), .out_instr(in1),
        .opcode(op1), .rdest(rd1), .rsrc(rs1), .imm(im1), .jump_addr(ja1));

    if_stage_param #(.PREDECODE(0)) dut_nopd (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .out_ready(out_ready), .out_valid(v2), .out_pc(pc2), .out_instr(in2),
        .opcode(op2), .rdest(rd2), .rsrc(rs2), .imm(im2), .jump_addr(ja2));

    typedef struct {
        logic       rst, fe, rdy, rv;
        logic [7:0] ra;
        logic       we;
        logic [7:0] pa, pd;
        logic       ev;
        logic [7:0] epc, ein, epc2;
        logic       cj;
        logic [7:0] ejmp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic fe, logic rdy, logic rv, logic [7:0] ra,
                                logic we, logic [7:0] pa, logic [7:0] pd,
                                logic ev, logic [7:0] epc, logic [7:0] ein, logic [7:0] epc2,
                                logic cj, logic [7:0] ejmp);
        vec_t v;
        v.rst = rst; v.fe = fe; v.rdy = rdy; v.rv = rv; v.ra = ra;
        v.we = we; v.pa = pa; v.pd = pd;
        v.ev = ev; v.epc = epc; v.ein = ein; v.epc2 = epc2; v.cj = cj; v.ejmp = ejmp;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] init_img [5];

    initial begin
        init_img = '{8'h08, 8'h4B, 8'h42, 8'h00, 8'h00};

        // rst fe rdy rv ra     we pa     pd      ev epc    ein    epc2   cj jmp
        tbl.push_back(mk(1,1,1,0,8'h00, 0,8'h00,8'h00, 0,8'h00,8'h00,8'h00, 0,8'h00)); // 0 reset
        tbl.push_back(mk(0,1,1,0,8'h00, 0,8'h00,8'h00, 1,8'h00,8'h08,8'h00, 0,8'h00)); // 1
        tbl.push_back(mk(0,1,1,0,8'h00, 0,8'h00,8'h00, 1,8'h01,8'h4B,8'h01, 0,8'h00)); // 2
        tbl.push_back(mk(0,1,1,0,8'h00, 0,8'h00,8'h00, 1,8'h02,8'h42,8'h02, 0,8'h00)); // 3
        tbl.push_back(mk(0,1,0,0,8'h00, 1,8'h04,8'hC5, 1,8'h02,8'h42,8'h02, 0,8'h00)); // 4 stall
        tbl.push_back(mk(0,1,0,0,8'h00, 0,8'h00,8'h00, 1,8'h02,8'h42,8'h02, 0,8'h00)); // 5
        tbl.push_back(mk(0,1,0,0,8'h00, 0,8'h00,8'h00, 1,8'h02,8'h42,8'h02, 0,8'h00)); // 6
        tbl.push_back(mk(0,1,1,0,8'h00, 0,8'h00,8'h00, 1,8'h03,8'h00,8'h03, 0,8'h00)); // 7
        tbl.push_back(mk(0,1,1,0,8'h00, 0,8'h00,8'h00, 1,8'h04,8'hC5,8'h04, 1,8'h05)); // 8 jump 5
        tbl.push_back(mk(0,1,1,0,8'h00, 0,8'h00,8'h00, 1,8'h05,8'h00,8'h05, 0,8'h00)); // 9
        tbl.push_back(mk(0,1,1,1,8'h04, 1,8'h04,8'hE0, 0,8'h00,8'h00,8'h00, 0,8'h00)); // 10
        tbl.push_back(mk(0,1,1,0,8'h00, 0,8'h00,8'h00, 1,8'h04,8'hE0,8'h04, 1,8'h20)); // 11
        tbl.push_back(mk(0,1,1,0,8'h00, 0,8'h00,8'h00, 1,8'h20,8'h00,8'h05, 0,8'h00)); // 12 jump 0x20
        tbl.push_back(mk(0,1,0,1,8'h02, 0,8'h00,8'h00, 0,8'h00,8'h00,8'h00, 0,8'h00)); // 13 flush
        tbl.push_back(mk(0,1,1,0,8'h00, 0,8'h00,8'h00, 1,8'h02,8'h42,8'h02, 0,8'h00)); // 14
        tbl.push_back(mk(0,1,1,1,8'hFE, 0,8'h00,8'h00, 0,8'h00,8'h00,8'h00, 0,8'h00)); // 15
        tbl.push_back(mk(0,1,1,0,8'h00, 0,8'h00,8'h00, 1,8'hFE,8'h00,8'hFE, 0,8'h00)); // 16
        tbl.push_back(mk(0,1,1,0,8'h00, 0,8'h00,8'h00, 1,8'hFF,8'h00,8'hFF, 0,8'h00)); // 17
        tbl.push_back(mk(0,1,1,0,8'h00, 0,8'h00,8'h00, 1,8'h00,8'h08,8'h00, 0,8'h00)); // 18 wrap
        tbl.push_back(mk(0,1,1,1,8'h03, 0,8'h00,8'h00, 0,8'h00,8'h00,8'h00, 0,8'h00)); // 19
        tbl.push_back(mk(0,1,1,0,8'h00, 1,8'h03,8'h5A, 1,8'h03,8'h00,8'h03, 0,8'h00)); // 20 old data
        tbl.push_back(mk(0,1,1,1,8'h03, 0,8'h00,8'h00, 0,8'h00,8'h00,8'h00, 0,8'h00)); // 21
        tbl.push_back(mk(0,1,1,0,8'h00, 0,8'h00,8'h00, 1,8'h03,8'h5A,8'h03, 0,8'h00)); // 22 new data
        tbl.push_back(mk(0,1,1,0,8'h00, 0,8'h00,8'h00, 1,8'h04,8'hE0,8'h04, 1,8'h20)); // 23
        tbl.push_back(mk(1,1,1,0,8'h00, 0,8'h00,8'h00, 0,8'h00,8'h00,8'h00, 0,8'h00)); // 24 reset
        tbl.push_back(mk(0,1,1,0,8'h00, 0,8'h00,8'h00, 1,8'h00,8'h08,8'h00, 0,8'h00)); // 25
        tbl.push_back(mk(0,1,1,0,8'h00, 0,8'h00,8'h00, 1,8'h01,8'h4B,8'h01, 0,8'h00)); // 26
        tbl.push_back(mk(0,1,1,1,8'h03, 0,8'h00,8'h00, 0,8'h00,8'h00,8'h00, 0,8'h00)); // 27
        tbl.push_back(mk(0,1,1,0,8'h00, 0,8'h00,8'h00, 1,8'h03,8'h5A,8'h03, 0,8'h00)); // 28
        tbl.push_back(mk(0,0,0,0,8'h00, 1,8'h40,8'hFF, 1,8'h03,8'h5A,8'h03, 0,8'h00)); // 29 oob write
        tbl.push_back(mk(0,0,1,0,8'h00, 0,8'h00,8'h00, 0,8'h00,8'h00,8'h00, 0,8'h00)); // 30 drain
        tbl.push_back(mk(0,1,1,0,8'h00, 0,8'h00,8'h00, 1,8'h04,8'hE0,8'h04, 0,8'h00)); // 31
        tbl.push_back(mk(0,1,1,1,8'h00, 0,8'h00,8'h00, 0,8'h00,8'h00,8'h00, 0,8'h00)); // 32
        tbl.push_back(mk(0,1,1,0,8'h00, 0,8'h00,8'h00, 1,8'h00,8'h08,8'h00, 0,8'h00)); // 33

        // Program load under reset: image in 0..4, NOP elsewhere.
        reset = 1'b1; fetch_en = 1'b0; out_ready = 1'b1;
        redirect_valid = 1'b0; redirect_addr = '0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        #1;
        for (int i = 0; i < 64; i++) begin
            prog_we   = 1'b1;
            prog_addr = 8'(i);
            prog_data = (i < 5) ? init_img[i] : 8'h00;
            tick();
        end
        prog_we = 1'b0;

        foreach (tbl[n]) begin
            reset = tbl[n].rst; fetch_en = tbl[n].fe; out_ready = tbl[n].rdy;
            redirect_valid = tbl[n].rv; redirect_addr = tbl[n].ra;
            prog_we = tbl[n].we; prog_addr = tbl[n].pa; prog_data = tbl[n].pd;
            tick();
            chk($sformatf("row%0d valid", n), 32'(v1), 32'(tbl[n].ev));
            chk($sformatf("row%0d valid_nopd", n), 32'(v2), 32'(tbl[n].ev));
            if (tbl[n].ev || tbl[n].rst) begin
                chk($sformatf("row%0d pc", n), 32'(pc1), 32'(tbl[n].epc));
                chk($sformatf("row%0d instr", n), 32'(in1), 32'(tbl[n].ein));
                chk($sformatf("row%0d opcode", n), 32'(op1), 32'(tbl[n].ein[7:6]));
                chk($sformatf("row%0d rdest", n), 32'(rd1), 32'(tbl[n].ein[5:3]));
                chk($sformatf("row%0d rsrc", n), 32'(rs1), 32'(tbl[n].ein[2:0]));
                chk($sformatf("row%0d imm", n), 32'(im1), 32'(tbl[n].ein[2:0]));
                chk($sformatf("row%0d pc_nopd", n), 32'(pc2), 32'(tbl[n].epc2));
            end
            if (tbl[n].cj)
                chk($sformatf("row%0d jump_addr", n), 32'(ja1), 32'(tbl[n].ejmp));
            if (n == 2) begin
                chk("pc1 opcode", 32'(op1), 32'h1);
                chk("pc1 rdest", 32'(rd1), 32'h1);
                chk("pc1 rsrc", 32'(rs1), 32'h3);
                chk("pc1 imm", 32'(im1), 32'h3);
            end
        end

        // Long stall: outputs must stay put across many cycles, then resume.
        out_ready = 1'b0; redirect_valid = 1'b0; prog_we = 1'b0; fetch_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("stall%0d valid", k), 32'(v1), 32'h1);
            chk($sformatf("stall%0d pc", k), 32'(pc1), 32'h00);
            chk($sformatf("stall%0d instr", k), 32'(in1), 32'h08);
        end
        out_ready = 1'b1;
        tick();
        chk("post_stall pc", 32'(pc1), 32'h01);
        chk("post_stall instr", 32'(in1), 32'h4B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_stage_param.md
Name: if_stage_param

Overview:
- Parametrised, pipelined instruction-fetch stage.
- Holds a program counter and a loadable instruction memory, and fetches one instruction per cycle into an IF/ID output register.
- The output register carries a valid/ready handshake, so a downstream stall holds the fetched instruction in place.
- Adds three capabilities to the basic fetch function:
  - redirect/flush from a later stage,
  - optional local jump predecode,
  - a runtime program-load port (memory is no longer hard-coded at reset).

Parameters:
- INSTR_W, 8, instruction width; must equal OPC_W + 2*REG_W.
- OPC_W, 2, opcode field width (MSBs of instruction).
- REG_W, 3, register-specifier width (rdest, then rsrc).
- ADDR_W, 8, PC / instruction-address width.
- DEPTH, 64, instruction memory entries; must be ≤ 2^ADDR_W.
- JMP_OPC, 2'b11, opcode value treated as unconditional jump.
- PREDECODE, 1, 1 = fetch stage redirects itself on JMP_OPC; 0 = no local redirect.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- fetch_en  in  1  1 = fetch allowed this cycle.
- redirect_valid  in  1  later-stage redirect (taken branch/jump).
- redirect_addr  in  ADDR_W  redirect target.
- prog_we  in  1  instruction memory write enable.
- prog_addr  in  ADDR_W  write address.
- prog_data  in  INSTR_W  write data.
- out_ready  in  1  downstream can accept the output register.
- out_valid  out  1  output register holds a live instruction.
- out_pc  out  ADDR_W  address of the held instruction.
- out_instr  out  INSTR_W  raw instruction.
- opcode  out  OPC_W  instr[INSTR_W-1 -: OPC_W].
- rdest  out  REG_W  next REG_W bits below opcode.
- rsrc  out  REG_W  low REG_W bits.
- imm  out  REG_W  equals rsrc.
- jump_addr  out  ADDR_W  {out_pc[ADDR_W-1 : INSTR_W-OPC_W], instr[INSTR_W-OPC_W-1:0]}; if ADDR_W ≤ INSTR_W-OPC_W, low ADDR_W bits of the instruction field.

Behaviour:
- Reset (synchronous, active-high):
  - pc = 0.
  - out_valid = 0.
  - out_pc, out_instr and all decoded fields = 0.
  - Memory contents are not reset; they are preserved through reset.
  - Reset mid-operation discards the held instruction and any pending redirect.
- Memory:
  - Combinational read of mem[pc].
  - Addresses ≥ DEPTH read as all-zeros (NOP).
  - Write: when prog_we=1 and prog_addr < DEPTH, mem[prog_addr] ← prog_data at clk edge; out-of-range writes are ignored.
  - Read and write to the same address in the same cycle: the fetch returns the old data.
- advance = !out_valid || out_ready.
- Priority per cycle (highest first):
  - reset.
  - redirect_valid=1: pc ← redirect_addr; out_valid ← 0 (flush), regardless of out_ready or fetch_en.
  - advance && fetch_en:
    - Output register ← mem[pc] with out_pc ← pc, and out_valid ← 1.
    - If PREDECODE=1 and the fetched opcode == JMP_OPC: pc ← jump target computed from pc and the fetched instruction (same formula as jump_addr).
    - Otherwise pc ← pc+1, wrapping modulo 2^ADDR_W.
  - advance && !fetch_en: out_valid ← 0 if out_ready (or already 0); pc holds.
  - !advance (stall): pc and the output register hold unchanged.
- Latency: the instruction at pc appears on the outputs one cycle after the fetch edge.
- Throughput: one instruction per cycle while out_ready=1.
- A local jump costs no bubble: the target is fetched on the next cycle.
- A redirect costs exactly one bubble cycle (out_valid=0), then the target instruction becomes valid.
- Decoded fields are registered alongside out_instr and are always consistent with it.
- Handshake: a transfer occurs on a cycle where out_valid && out_ready. While out_valid=1 && out_ready=0, all outputs are stable.

Test Plan:
- Load mem[0..4] = 00_001_000, 01_001_011, 01_000_010, 00_000_000, 00_000_000; deassert reset; fetch_en=1, out_ready=1.
  - Required: out_valid rises 1 cycle after reset release.
  - Required: out_pc = 0,1,2,3 on consecutive cycles.
  - Required for pc=1: opcode=01, rdest=001, rsrc=imm=011.
- Stall: hold out_ready=0 for 3 cycles while out_pc=2.
  - Required: out_pc and out_instr unchanged during the stall.
  - Required: out_pc=3 on the cycle after out_ready returns to 1.
- Local jump: mem[4] = 11_000_101, PREDECODE=1.
  - Required: the cycle after out_pc=4 shows out_pc=5; jump_addr=0x05 while out_pc=4.
  - Repeat with mem[4] = 11_100_000: the next out_pc is 0x20.
  - Repeat with PREDECODE=0: the next out_pc is 5 for mem[4] = 11_100_000.
- Redirect redirect_valid=1, redirect_addr=0x02 while out_valid=1 and out_ready=0.
  - Required: next cycle out_valid=0.
  - Required: following cycle out_pc=2, out_valid=1.
- Boundaries:
  - pc reaches 0xFF with DEPTH=64: out_instr=0 (NOP), and the next out_pc is 0x00 (wrap).
  - prog_we to address 3 in the same cycle pc=3 is fetched: the old value is delivered, and a refetch of 3 returns the new value.
- Assert reset for 1 cycle mid-stream with out_valid=1.
  - Required: next cycle out_valid=0, then out_pc=0.
  - Required: memory contents unchanged.
